mult_mem_arbiter: RTL and testbench

MULT_MEM_ARBITER -- requirements
Module: mult_mem_arbiter

---
 rtl/mult_mem_arbiter_if.sv | 55 +++++
 rtl/mult_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mult_mem_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mult_mem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a single-port synchronous memory.
// The dbg_state signal carries the arbiter FSM state: 0 = IDLE, 1 = OWN0, 2 = OWN1.
interface mult_mem_arbiter_if #(
    parameter int LOGDEPTH = 6,
    parameter int WIDTH    = 32
);
    // Handshake: a beat transfers on a cycle where reqn_valid && reqn_ready.
    // reqn_ready is never high without reqn_valid.
    // At most one reqn_ready is high per cycle.
    logic                req0_valid;
    logic                req0_write;
    logic                req0_lock;
    logic [LOGDEPTH-1:0] req0_addr;
    logic [WIDTH-1:0]    req0_wdata;
    logic                req0_ready;
    logic                rsp0_valid;
    logic [WIDTH-1:0]    rsp0_rdata;

    logic                req1_valid;
    logic                req1_write;
    logic                req1_lock;
    logic [LOGDEPTH-1:0] req1_addr;
    logic [WIDTH-1:0]    req1_wdata;
    logic                req1_ready;
    logic                rsp1_valid;
    logic [WIDTH-1:0]    rsp1_rdata;

    logic                mem_en;
    logic                mem_we;
    logic [LOGDEPTH-1:0] mem_addr;
    logic [WIDTH-1:0]    mem_wdata;
    logic [WIDTH-1:0]    mem_rdata;

    logic [1:0]          dbg_state;

    modport slave (
        input  req0_valid, req0_write, req0_lock, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_lock, req1_addr, req1_wdata,
        input  mem_rdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output dbg_state
    );

    modport master (
        output req0_valid, req0_write, req0_lock, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_lock, req1_addr, req1_wdata,
        output mem_rdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  dbg_state
    );
endinterface

// File: rtl/mult_mem_arbiter.sv
// Two-requester arbiter with lock/ownership onto one synchronous memory port.
// Define MULT_MEM_ARBITER_RR_EN for round-robin IDLE arbitration; default is fixed priority to requester 0.
module mult_mem_arbiter #(
    parameter int LOGDEPTH = 6,
    parameter int WIDTH    = 32,
    parameter int LOCK_MAX = 64
) (
    input logic               clk,
    input logic               rst,
    mult_mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t              r_state, w_next;
    logic [CW-1:0]       r_cnt, w_cnt_next;
    logic                r_fav_pend, r_fav_id;
    logic                w_fav_set, w_fav_id;
    logic                w_pri1, w_rdy0, w_rdy1, w_beat;
    logic                r_mem_en, r_mem_we, r_mem_src;
    logic [LOGDEPTH-1:0] r_mem_addr;
    logic [WIDTH-1:0]    r_mem_wdata;
    logic                r_rsp_pend, r_rsp_src;

`ifdef MULT_MEM_ARBITER_RR_EN
    logic r_rr_ptr;

    always_ff @(posedge clk) begin
        if (rst)
            r_rr_ptr <= 1'b0;
        else if (r_state == ST_IDLE && w_beat)
            r_rr_ptr <= ~w_rdy1;
    end

    assign w_pri1 = r_fav_pend ? r_fav_id : r_rr_ptr;
`else
    assign w_pri1 = r_fav_pend & r_fav_id;
`endif

    // The locking beat that enters OWNn counts as the first locked beat.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_rdy0     = 1'b0;
        w_rdy1     = 1'b0;
        w_fav_set  = 1'b0;
        w_fav_id   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pri1) begin
                    w_rdy1 = bus.req1_valid;
                    w_rdy0 = bus.req0_valid & ~bus.req1_valid;
                end else begin
                    w_rdy0 = bus.req0_valid;
                    w_rdy1 = bus.req1_valid & ~bus.req0_valid;
                end
                if (w_rdy0 && bus.req0_lock) begin
                    w_next     = ST_OWN0;
                    w_cnt_next = CW'(1);
                end else if (w_rdy1 && bus.req1_lock) begin
                    w_next     = ST_OWN1;
                    w_cnt_next = CW'(1);
                end
            end
            ST_OWN0: begin
                if (r_cnt == CW'(LOCK_MAX) && bus.req1_valid) begin
                    w_next    = ST_IDLE;
                    w_fav_set = 1'b1;
                    w_fav_id  = 1'b1;
                end else begin
                    w_rdy0 = bus.req0_valid;
                    if (bus.req0_valid) begin
                        if (!bus.req0_lock) w_next = ST_IDLE;
                        if (r_cnt != CW'(LOCK_MAX)) w_cnt_next = r_cnt + CW'(1);
                    end
                end
            end
            ST_OWN1: begin
                if (r_cnt == CW'(LOCK_MAX) && bus.req0_valid) begin
                    w_next    = ST_IDLE;
                    w_fav_set = 1'b1;
                    w_fav_id  = 1'b0;
                end else begin
                    w_rdy1 = bus.req1_valid;
                    if (bus.req1_valid) begin
                        if (!bus.req1_lock) w_next = ST_IDLE;
                        if (r_cnt != CW'(LOCK_MAX)) w_cnt_next = r_cnt + CW'(1);
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
        if (rst) begin
            w_rdy0 = 1'b0;
            w_rdy1 = 1'b0;
        end
    end

    assign w_beat = w_rdy0 | w_rdy1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_fav_pend <= 1'b0;
            r_fav_id   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_next;
            r_fav_pend <= w_fav_set;
            r_fav_id   <= w_fav_id;
        end
    end

    // Stage 1 issues the memory command; stage 2 returns read data to its origin.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_src   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_pend  <= 1'b0;
            r_rsp_src   <= 1'b0;
        end else begin
            r_mem_en   <= w_beat;
            r_mem_we   <= w_beat & (w_rdy1 ? bus.req1_write : bus.req0_write);
            r_rsp_pend <= r_mem_en & ~r_mem_we;
            r_rsp_src  <= r_mem_src;
            if (w_beat) begin
                r_mem_src   <= w_rdy1;
                r_mem_addr  <= w_rdy1 ? bus.req1_addr : bus.req0_addr;
                r_mem_wdata <= w_rdy1 ? bus.req1_wdata : bus.req0_wdata;
            end
        end
    end

    assign bus.req0_ready = w_rdy0;
    assign bus.req1_ready = w_rdy1;
    assign bus.mem_en     = r_mem_en;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.rsp0_valid = r_rsp_pend & ~r_rsp_src;
    assign bus.rsp1_valid = r_rsp_pend & r_rsp_src;
    assign bus.rsp0_rdata = (r_rsp_pend && !r_rsp_src) ? bus.mem_rdata : '0;
    assign bus.rsp1_rdata = (r_rsp_pend && r_rsp_src) ? bus.mem_rdata : '0;
    assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_mult_mem_arbiter.sv
// Directed bench for mult_mem_arbiter: reset, write/read forwarding, arbitration, lock hold,
// forced lock release and reset with a read in flight.
module tb_mult_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    mult_mem_arbiter_if #(.LOGDEPTH(6), .WIDTH(32)) bus ();

    mult_mem_arbiter #(.LOGDEPTH(6), .WIDTH(32), .LOCK_MAX(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous memory: read data appears the cycle after the read strobe.
    logic [31:0] mem_model [64];
    logic [31:0] rdata_q = '0;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wdata;
            else            rdata_q <= mem_model[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = rdata_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic w, input logic l, input logic [5:0] a, input logic [31:0] d);
        bus.req0_valid = v; bus.req0_write = w; bus.req0_lock = l; bus.req0_addr = a; bus.req0_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic w, input logic l, input logic [5:0] a, input logic [31:0] d);
        bus.req1_valid = v; bus.req1_write = w; bus.req1_lock = l; bus.req1_addr = a; bus.req1_wdata = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive0(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
        drive1(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    logic [1:0] exp_grant [4];
    int         n0;

    initial begin
        for (int i = 0; i < 64; i++) mem_model[i] = '0;
`ifdef MULT_MEM_ARBITER_RR_EN
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
`else
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b01; exp_grant[2] = 2'b01; exp_grant[3] = 2'b01;
`endif
        // Reset: readies gated even with valids high.
        rst = 1'b1;
        drive0(1'b1, 1'b0, 1'b0, 6'd3, 32'd0);
        drive1(1'b1, 1'b0, 1'b0, 6'd4, 32'd0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_ready", {31'd0, bus.req0_ready | bus.req1_ready}, 32'd0);
        check("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_mem_addr", {26'd0, bus.mem_addr}, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_rsp", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        check("rst_state", {30'd0, bus.dbg_state}, 32'd0);
        do_reset();

        // Write then read to the same address back to back.
        drive0(1'b1, 1'b1, 1'b0, 6'd5, 32'h1234);
        @(negedge clk);
        check("wr_ready", {31'd0, bus.req0_ready}, 32'd1);
        next_cycle();
        drive0(1'b1, 1'b0, 1'b0, 6'd5, 32'd0);
        @(negedge clk);
        check("rd_ready", {31'd0, bus.req0_ready}, 32'd1);
        check("wr_mem_en", {31'd0, bus.mem_en}, 32'd1);
        check("wr_mem_we", {31'd0, bus.mem_we}, 32'd1);
        check("wr_mem_addr", {26'd0, bus.mem_addr}, 32'd5);
        check("wr_mem_wdata", bus.mem_wdata, 32'h1234);
        next_cycle();
        drive0(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
        @(negedge clk);
        check("rd_mem_en", {31'd0, bus.mem_en}, 32'd1);
        check("rd_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rd_mem_addr", {26'd0, bus.mem_addr}, 32'd5);
        check("wr_no_rsp", {31'd0, bus.rsp0_valid}, 32'd0);
        check("rdata_idle_zero", bus.rsp0_rdata, 32'd0);
        next_cycle();
        @(negedge clk);
        check("rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
        check("rsp0_rdata", bus.rsp0_rdata, 32'h1234);
        check("rsp1_quiet", {31'd0, bus.rsp1_valid}, 32'd0);
        check("mem_en_drop", {31'd0, bus.mem_en}, 32'd0);
        next_cycle();

        // Both requesters reading for four cycles.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive0(c < 4, 1'b0, 1'b0, 6'd5, 32'd0);
            drive1(c < 4, 1'b0, 1'b0, 6'd5, 32'd0);
            @(negedge clk);
            if (c < 4)
                check($sformatf("grant_c%0d", c), {30'd0, bus.req1_ready, bus.req0_ready}, {30'd0, exp_grant[c]});
            if (c >= 2) begin
                check($sformatf("rsp_route_c%0d", c), {30'd0, bus.rsp1_valid, bus.rsp0_valid}, {30'd0, exp_grant[c-2]});
                check($sformatf("rsp_data_c%0d", c), bus.rsp0_rdata | bus.rsp1_rdata, 32'h1234);
            end
            next_cycle();
        end

        // Requester 1 locks for three beats, releases on the fourth; one owner cycle without valid.
        drive1(1'b1, 1'b1, 1'b1, 6'd10, 32'hA1);
        @(negedge clk);
        check("lk_grant1", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd2);
        next_cycle();
        drive0(1'b1, 1'b1, 1'b0, 6'd20, 32'hB0);
        drive1(1'b0, 1'b1, 1'b1, 6'd11, 32'hA2);
        @(negedge clk);
        check("lk_state_own1", {30'd0, bus.dbg_state}, 32'd2);
        check("lk_hold_no_grant", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        next_cycle();
        for (int b = 2; b <= 4; b++) begin
            drive1(1'b1, 1'b1, b < 4, 6'(10 + b), 32'hA0 + 32'(b));
            @(negedge clk);
            check($sformatf("lk_beat%0d", b), {30'd0, bus.req1_ready, bus.req0_ready}, 32'd2);
            next_cycle();
        end
        drive1(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
        @(negedge clk);
        check("lk_release_state", {30'd0, bus.dbg_state}, 32'd0);
        check("lk_req0_after", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
        next_cycle();

        // Requester 0 locked indefinitely while requester 1 waits: forced release.
        do_reset();
        drive0(1'b1, 1'b1, 1'b1, 6'd30, 32'hC0);
        drive1(1'b1, 1'b1, 1'b0, 6'd31, 32'hD0);
        n0 = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.req0_ready) break;
            n0++;
            next_cycle();
        end
        check("force_beats", 32'(n0), 32'd64);
        check("force_gap", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        check("force_state_own0", {30'd0, bus.dbg_state}, 32'd1);
        next_cycle();
        @(negedge clk);
        check("force_req1_next", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd2);
        next_cycle();

        // Reset with a read in flight suppresses its response.
        do_reset();
        drive0(1'b1, 1'b0, 1'b0, 6'd5, 32'd0);
        @(negedge clk);
        check("inflt_ready", {31'd0, bus.req0_ready}, 32'd1);
        next_cycle();
        rst = 1'b1;
        drive0(1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
        @(negedge clk);
        check("inflt_strobe", {31'd0, bus.mem_en}, 32'd1);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("inflt_no_rsp", {31'd0, bus.rsp0_valid}, 32'd0);
        check("inflt_rdata", bus.rsp0_rdata, 32'd0);
        check("inflt_mem_en", {31'd0, bus.mem_en}, 32'd0);
        check("inflt_mem_addr", {26'd0, bus.mem_addr}, 32'd0);
        check("inflt_state", {30'd0, bus.dbg_state}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
